// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave responder: mode and state enums,
// word-length encodings and the bits-per-word function.
package spi_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  localparam logic [1:0] WLEN_8  = 2'b00;
  localparam logic [1:0] WLEN_16 = 2'b01;
  localparam logic [1:0] WLEN_24 = 2'b10;
  localparam logic [1:0] WLEN_32 = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SHIFT   = 2'b01,
    WAIT_CS = 2'b10,
    ARM     = 2'b11
  } spi_state_t;

  // 8 * (word_len + 1); fits the 6-bit counter (max 32).
  function automatic logic [CNT_W-1:0] word_bits(input logic [1:0] word_len);
    return {1'b0, word_len, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus an edge-detect
// register producing single-cycle rise and fall strobes.
module spi_pin_sync (
  input  logic clk,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;

  // NOTE: synchronizer flops carry no reset so they keep tracking the pin
  // during reset; the FSM reset value depends on the synchronized CS level.
  always_ff @(posedge clk) begin
    sync1_q <= pin_i;
    sync2_q <= sync1_q;
    prev_q  <= sync2_q;
  end

  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
  assign fall_o  = ~sync2_q & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// SPI slave responder: oversamples CS/SCK/MOSI on CLK, shifts in one word per
// CS assertion in any SPI mode, returns a preloaded word on MISO MSB first.
module spi_slave_responder
  import spi_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        spi_mode_i,
  input  logic [1:0]        word_len_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              CS_i,
  input  logic              SCK_i,
  input  logic              MOSI_i,
  output logic              MISO_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              frame_err_o
);

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_pin_sync u_cs_sync (
    .clk     (CLK),
    .pin_i   (CS_i),
    .level_o (cs_level),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall)
  );

  spi_pin_sync u_sck_sync (
    .clk     (CLK),
    .pin_i   (SCK_i),
    .level_o (sck_level),
    .rise_o  (sck_rise),
    .fall_o  (sck_fall)
  );

  spi_pin_sync u_mosi_sync (
    .clk     (CLK),
    .pin_i   (MOSI_i),
    .level_o (mosi_level),
    .rise_o  (mosi_rise),
    .fall_o  (mosi_fall)
  );

  logic unused_ok;
  assign unused_ok = &{1'b0, sck_level, mosi_rise, mosi_fall};

  spi_state_t        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [1:0]        wlen_q, wlen_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              miso_q, miso_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;

  logic [1:0]        mode_bits;
  logic              cpol, cpha;
  logic              leading_ev, trailing_ev, sample_ev, shift_ev;
  logic [CNT_W-1:0]  nbits;
  logic [DATA_W-1:0] tx_aligned;
  logic              last_sample;

  assign mode_bits   = mode_q;
  assign cpol        = mode_bits[1];
  assign cpha        = mode_bits[0];
  assign leading_ev  = cpol ? sck_fall : sck_rise;
  assign trailing_ev = cpol ? sck_rise : sck_fall;
  assign sample_ev   = cpha ? trailing_ev : leading_ev;
  assign shift_ev    = cpha ? leading_ev : trailing_ev;
  assign nbits       = word_bits(wlen_q);
  assign last_sample = sample_ev && ((count_q + 6'd1) == nbits);

  // The outgoing word is kept MSB-aligned at bit 31 whatever its length.
  assign tx_aligned  = tx_data_i << (6'd32 - word_bits(word_len_i));

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    wlen_d      = wlen_q;
    count_d     = count_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    rx_data_d   = rx_data_q;
    miso_d      = miso_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          mode_d  = spi_mode_t'(spi_mode_i);
          wlen_d  = word_len_i;
          count_d = '0;
          rx_sr_d = '0;
          if (spi_mode_i[0]) begin
            tx_sr_d = tx_aligned;
          end else begin
            miso_d  = tx_aligned[DATA_W-1];
            tx_sr_d = tx_aligned << 1;
          end
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (count_q == nbits) begin
          // Completion one cycle after the Nth sample; CS may already be high.
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          miso_d     = 1'b0;
          state_d    = cs_level ? IDLE : WAIT_CS;
        end else begin
          if (sample_ev) begin
            rx_sr_d = {rx_sr_q[DATA_W-2:0], mosi_level};
            count_d = count_q + 6'd1;
          end
          if (shift_ev) begin
            miso_d  = tx_sr_q[DATA_W-1];
            tx_sr_d = tx_sr_q << 1;
          end
          if (cs_rise && !last_sample) begin
            frame_err_d = 1'b1;
            miso_d      = 1'b0;
            state_d     = IDLE;
          end
        end
      end

      WAIT_CS: begin
        miso_d = 1'b0;
        if (cs_level) state_d = IDLE;
      end

      ARM: begin
        miso_d = 1'b0;
        if (cs_level) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Held one extra cycle after leaving the frame so busy drops 4 CLK after CS.
    busy_d = (state_d == SHIFT) || (state_d == WAIT_CS) ||
             (state_q == SHIFT) || (state_q == WAIT_CS);
  end

  // NOTE: sequential state uses non-blocking assignments only; the blocking
  // ones live in always_comb above.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= cs_level ? IDLE : ARM;
      mode_q      <= MODE0;
      wlen_q      <= WLEN_8;
      count_q     <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_data_q   <= '0;
      miso_q      <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      wlen_q      <= wlen_d;
      count_q     <= count_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      rx_data_q   <= rx_data_d;
      miso_q      <= miso_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign MISO_o      = miso_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign busy_o      = busy_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a behavioural SPI master drives the
// pins, and immediate assertions compare results with hand-computed words.
module tb_spi_slave_responder;

  localparam int HALF = 50;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [1:0]  spi_mode_i = 2'b00;
  logic [1:0]  word_len_i = 2'b00;
  logic [31:0] tx_data_i = '0;
  logic        CS_i = 1'b1;
  logic        SCK_i = 1'b0;
  logic        MOSI_i = 1'b0;
  logic        MISO_o;
  logic [31:0] rx_data_o;
  logic        rx_valid_o;
  logic        busy_o;
  logic        frame_err_o;

  int checks = 0;
  int errors = 0;
  int rx_pulses = 0;
  int fe_pulses = 0;
  int both_pulses = 0;

  spi_slave_responder dut (
    .CLK         (CLK),
    .RST         (RST),
    .spi_mode_i  (spi_mode_i),
    .word_len_i  (word_len_i),
    .tx_data_i   (tx_data_i),
    .CS_i        (CS_i),
    .SCK_i       (SCK_i),
    .MOSI_i      (MOSI_i),
    .MISO_o      (MISO_o),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (rx_valid_o) rx_pulses++;
    if (frame_err_o) fe_pulses++;
    if (rx_valid_o && frame_err_o) both_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One master transaction: nclk SCK cycles, optional RST pulse after the
  // leading edge of cycle rst_bit. Collects the first N MISO bits, ORs any MISO
  // seen after bit N, and samples busy at cycle 1 and at the last cycle.
  task automatic spi_xfer(input logic [1:0] mode, input logic [1:0] wl,
                          input logic [31:0] mosi_word, input logic [31:0] tx_word,
                          input int nclk, input int rst_bit,
                          output logic [31:0] miso_word, output logic late_miso,
                          output logic busy_mid, output logic busy_late);
    int  n;
    logic cpol, cpha;
    n         = 8 * (int'(wl) + 1);
    cpol      = mode[1];
    cpha      = mode[0];
    miso_word = '0;
    late_miso = 1'b0;
    busy_mid  = 1'b0;
    busy_late = 1'b0;
    spi_mode_i = mode;
    word_len_i = wl;
    tx_data_i  = tx_word;
    SCK_i      = cpol;
    MOSI_i     = cpha ? 1'b0 : mosi_word[n-1];
    #(2 * HALF);
    CS_i = 1'b0;
    #HALF;
    for (int i = 0; i < nclk; i++) begin
      SCK_i = ~cpol;
      if (cpha) MOSI_i = (i < n) ? mosi_word[n-1-i] : 1'b1;
      else if (i < n) miso_word = {miso_word[30:0], MISO_o};
      else late_miso = late_miso | MISO_o;
      if (i == 1) busy_mid = busy_o;
      if (i == nclk - 1) busy_late = busy_o;
      if (i == rst_bit) begin
        RST = 1'b1;
        #20;
        RST = 1'b0;
        #(HALF - 20);
      end else begin
        #HALF;
      end
      SCK_i = cpol;
      if (cpha) begin
        if (i < n) miso_word = {miso_word[30:0], MISO_o};
        else late_miso = late_miso | MISO_o;
      end else begin
        MOSI_i = (i + 1 < n) ? mosi_word[n-2-i] : 1'b1;
      end
      #HALF;
    end
    CS_i = 1'b1;
    #(3 * HALF);
  endtask

  logic [31:0] miso_w;
  logic        late_m, b_mid, b_late;
  int          rx0, fe0;

  initial begin
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset_miso",      {31'b0, MISO_o},      32'h0);
    check("reset_rx_data",   rx_data_o,            32'h0);
    check("reset_rx_valid",  {31'b0, rx_valid_o},  32'h0);
    check("reset_busy",      {31'b0, busy_o},      32'h0);
    check("reset_frame_err", {31'b0, frame_err_o}, 32'h0);

    // Mode 0, 8-bit
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b00, 2'b00, 32'hA5, 32'h3C, 8, -1, miso_w, late_m, b_mid, b_late);
    check("m0_miso",    miso_w,                        32'h3C);
    check("m0_rx_data", rx_data_o,                     32'h0000_00A5);
    check("m0_rx_cnt",  32'(rx_pulses - rx0),          32'd1);
    check("m0_fe_cnt",  32'(fe_pulses - fe0),          32'd0);
    check("m0_busy",    {31'b0, b_mid},                32'h1);
    check("m0_idle",    {31'b0, busy_o},               32'h0);

    // Mode 3, 32-bit
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b11, 2'b11, 32'hDEADBEEF, 32'h12345678, 32, -1, miso_w, late_m, b_mid, b_late);
    check("m3_miso",    miso_w,               32'h12345678);
    check("m3_rx_data", rx_data_o,            32'hDEADBEEF);
    check("m3_rx_cnt",  32'(rx_pulses - rx0), 32'd1);

    // Mode 1, 16-bit
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b01, 2'b01, 32'h8001, 32'hF00F, 16, -1, miso_w, late_m, b_mid, b_late);
    check("m1_miso",    miso_w,               32'h0000_F00F);
    check("m1_rx_data", rx_data_o,            32'h0000_8001);
    check("m1_rx_cnt",  32'(rx_pulses - rx0), 32'd1);

    // Mode 2, 16-bit
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b10, 2'b01, 32'h8001, 32'hF00F, 16, -1, miso_w, late_m, b_mid, b_late);
    check("m2_miso",    miso_w,               32'h0000_F00F);
    check("m2_rx_data", rx_data_o,            32'h0000_8001);
    check("m2_fe_cnt",  32'(fe_pulses - fe0), 32'd0);

    // CS released after 5 of 8 bits
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b00, 2'b00, 32'h5A, 32'hC3, 5, -1, miso_w, late_m, b_mid, b_late);
    check("short_fe_cnt",  32'(fe_pulses - fe0), 32'd1);
    check("short_rx_cnt",  32'(rx_pulses - rx0), 32'd0);
    check("short_rx_data", rx_data_o,            32'h0000_8001);
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b00, 2'b00, 32'h5A, 32'hC3, 8, -1, miso_w, late_m, b_mid, b_late);
    check("after_short_miso",    miso_w,               32'hC3);
    check("after_short_rx_data", rx_data_o,            32'h0000_005A);
    check("after_short_rx_cnt",  32'(rx_pulses - rx0), 32'd1);

    // RST at bit 10 of a 24-bit frame with CS held low
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b00, 2'b10, 32'h123456, 32'hFFFFFF, 24, 10, miso_w, late_m, b_mid, b_late);
    check("rst_rx_cnt",   32'(rx_pulses - rx0), 32'd0);
    check("rst_fe_cnt",   32'(fe_pulses - fe0), 32'd0);
    check("rst_busy",     {31'b0, b_late},      32'h0);
    check("rst_rx_data",  rx_data_o,            32'h0);
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b00, 2'b10, 32'h00ABCDEF, 32'h654321, 24, -1, miso_w, late_m, b_mid, b_late);
    check("post_rst_rx_data", rx_data_o,            32'h00AB_CDEF);
    check("post_rst_miso",    miso_w,               32'h0065_4321);
    check("post_rst_rx_cnt",  32'(rx_pulses - rx0), 32'd1);

    // 8-bit frame plus 4 extra SCK cycles
    rx0 = rx_pulses; fe0 = fe_pulses;
    spi_xfer(2'b00, 2'b00, 32'h96, 32'hFF, 12, -1, miso_w, late_m, b_mid, b_late);
    check("extra_rx_cnt",    32'(rx_pulses - rx0), 32'd1);
    check("extra_fe_cnt",    32'(fe_pulses - fe0), 32'd0);
    check("extra_rx_data",   rx_data_o,            32'h0000_0096);
    check("extra_miso",      miso_w,               32'hFF);
    check("extra_wait_miso", {31'b0, late_m},      32'h0);
    check("extra_wait_busy", {31'b0, b_late},      32'h1);

    check("never_both_pulses", 32'(both_pulses), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
